// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode->execute pipeline register for the 5-stage RV32 core. Captures the
//   decoded operands and the opaque EX/MEM/WB control bundle, supports hold
//   (downstream stall), flush (branch/trap kill) and load-use bubble insertion,
//   and registers the 2-bit forwarding selects for the EX-stage 3:1 operand
//   muxes. The selects are resolved in ID so the EX mux select is a flop output
//   with no comparator in front of it.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   hold              freeze every register (outputs unchanged)
//   flush             load a bubble instead of the ID instruction
//   id_*              decoded instruction fields presented by ID
//   mem_rd            destination of the instruction currently in MEM
//   mem_reg_write     MEM instruction writes mem_rd (already valid-qualified)
//   ex_*              registered copies of the id_* fields
//   fwd_a_sel/_b_sel  00 regfile, 01 WB result, 10 MEM ALU result
//   load_use_stall    combinational; IF/ID must hold while asserted
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              load_use_stall
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_reg_write;
  logic              r_mem_read;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;

  logic              w_ex_wr_nz;
  logic              w_mem_wr_nz;
  logic              w_load_use;
  logic              w_bubble;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // A writer targeting x0 never forwards, so rs==x0 can never match.
  assign w_ex_wr_nz  = r_valid & r_reg_write & (r_rd != '0);
  assign w_mem_wr_nz = mem_reg_write & (mem_rd != '0);

  assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));

  assign w_bubble = flush | w_load_use;

  // Current EX moves to MEM next cycle and is the youngest producer, so it
  // takes priority over current MEM (which moves to WB).
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (w_ex_wr_nz && (r_rd == id_rs1))         w_fwd_a = 2'b10;
    else if (w_mem_wr_nz && (mem_rd == id_rs1)) w_fwd_a = 2'b01;
    if (w_ex_wr_nz && (r_rd == id_rs2))         w_fwd_b = 2'b10;
    else if (w_mem_wr_nz && (mem_rd == id_rs2)) w_fwd_b = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_ctrl      <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
    end else if (!hold) begin
      if (w_bubble) begin
        r_valid     <= 1'b0;
        r_pc        <= '0;
        r_rs1       <= '0;
        r_rs2       <= '0;
        r_rd        <= '0;
        r_rd1       <= '0;
        r_rd2       <= '0;
        r_imm       <= '0;
        r_ctrl      <= '0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_fwd_a     <= 2'b00;
        r_fwd_b     <= 2'b00;
      end else begin
        r_valid     <= id_valid;
        r_pc        <= id_pc;
        r_rs1       <= id_rs1;
        r_rs2       <= id_rs2;
        r_rd        <= id_rd;
        r_rd1       <= id_rd1;
        r_rd2       <= id_rd2;
        r_imm       <= id_imm;
        r_ctrl      <= id_ctrl;
        r_reg_write <= id_reg_write & id_valid;
        r_mem_read  <= id_mem_read & id_valid;
        r_fwd_a     <= w_fwd_a;
        r_fwd_b     <= w_fwd_b;
      end
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign ex_rd1         = r_rd1;
  assign ex_rd2         = r_rd2;
  assign ex_imm         = r_imm;
  assign ex_ctrl        = r_ctrl;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign fwd_a_sel      = r_fwd_a;
  assign fwd_b_sel      = r_fwd_b;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;
  logic        id_reg_write;
  logic        id_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [15:0] ex_ctrl;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        load_use_stall;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction the EX stage should currently hold.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic [15:0] ctrl;
    logic        rw, mr;
    logic [1:0]  fa, fb;
  } ex_t;

  ex_t m;
  ex_t saved;
  int  n_assert = 0;
  int  n_fail   = 0;
  bit  auto_mem = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Where will EX get operand rs from: producer in EX now -> MEM result (2),
  // producer in MEM now -> WB result (1), else the register file (0).
  function automatic logic [1:0] ref_sel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (m.valid && m.rw && m.rd == rs) return 2'd2;
    if (mem_reg_write && mem_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ref_stall();
    return id_valid && m.valid && m.mr && m.rd != 5'd0 &&
           (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic ex_t ref_next();
    ex_t n;
    if (hold) return m;
    n = '0;
    if (flush || ref_stall()) return n;
    n.valid = id_valid;
    n.pc    = id_pc;
    n.rs1   = id_rs1;
    n.rs2   = id_rs2;
    n.rd    = id_rd;
    n.rd1   = id_rd1;
    n.rd2   = id_rd2;
    n.imm   = id_imm;
    n.ctrl  = id_ctrl;
    n.rw    = id_valid && id_reg_write;
    n.mr    = id_valid && id_mem_read;
    n.fa    = ref_sel(id_rs1);
    n.fb    = ref_sel(id_rs2);
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, m.valid});
    chk({tag, ".ex_pc"},        ex_pc,                 m.pc);
    chk({tag, ".ex_rs1"},       {27'd0, ex_rs1},       {27'd0, m.rs1});
    chk({tag, ".ex_rs2"},       {27'd0, ex_rs2},       {27'd0, m.rs2});
    chk({tag, ".ex_rd"},        {27'd0, ex_rd},        {27'd0, m.rd});
    chk({tag, ".ex_rd1"},       ex_rd1,                m.rd1);
    chk({tag, ".ex_rd2"},       ex_rd2,                m.rd2);
    chk({tag, ".ex_imm"},       ex_imm,                m.imm);
    chk({tag, ".ex_ctrl"},      {16'd0, ex_ctrl},      {16'd0, m.ctrl});
    chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk({tag, ".ex_mem_read"},  {31'd0, ex_mem_read},  {31'd0, m.mr});
    chk({tag, ".fwd_a_sel"},    {30'd0, fwd_a_sel},    {30'd0, m.fa});
    chk({tag, ".fwd_b_sel"},    {30'd0, fwd_b_sel},    {30'd0, m.fb});
  endtask

  // One clock: check the combinational stall, advance the model, check regs.
  // With auto_mem the MEM-stage inputs follow whatever left EX at this edge.
  task automatic step(input string tag);
    ex_t nxt;
    ex_t prev;
    #1;
    chk({tag, ".load_use_stall"}, {31'd0, load_use_stall}, {31'd0, ref_stall()});
    nxt  = ref_next();
    prev = m;
    @(posedge clk);
    m = nxt;
    #1;
    if (auto_mem && !hold) begin
      mem_rd        = prev.rd;
      mem_reg_write = prev.valid && prev.rw;
    end
    check_all(tag);
  endtask

  task automatic present(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_pc        = $urandom;
    id_rd1       = $urandom;
    id_rd2       = $urandom;
    id_imm       = $urandom;
    id_ctrl      = 16'($urandom);
  endtask

  task automatic drain();
    present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("drain");
    step("drain");
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0;
    present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    m = '0;
    #12;
    check_all("reset");
    chk("reset.load_use_stall", {31'd0, load_use_stall}, 32'd0);
    rst_n = 1'b1;

    // First capture after reset
    present(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
    step("first_capture");
    chk("first_capture.valid", {31'd0, ex_valid}, 32'd1);

    // Async reset mid-stream while hold is asserted
    hold = 1'b1;
    present(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    mem_rd = '0; mem_reg_write = 1'b0;
    check_all("async_reset");
    rst_n = 1'b1;
    #1;
    hold = 1'b0;
    step("post_reset");

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x1
    drain();
    present(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    step("alu_add");
    present(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    step("alu_sub");
    chk("alu_chain.fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("alu_chain.fwd_b", {30'd0, fwd_b_sel}, 32'd0);

    // Gap of one: add x5 ; nop ; or x7,x0,x5
    drain();
    present(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    step("gap_add");
    present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("gap_nop");
    present(1'b1, 5'd0, 5'd5, 5'd7, 1'b1, 1'b0);
    step("gap_or");
    chk("gap.fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("gap.fwd_b", {30'd0, fwd_b_sel}, 32'd1);

    // Load-use: lw x5 ; add x6,x5,x5
    drain();
    present(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    step("lu_lw");
    present(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    #1;
    chk("load_use.stall_on", {31'd0, load_use_stall}, 32'd1);
    step("lu_bubble");
    chk("load_use.bubble", {31'd0, ex_valid}, 32'd0);
    #1;
    chk("load_use.stall_off", {31'd0, load_use_stall}, 32'd0);
    step("lu_add");
    chk("load_use.valid", {31'd0, ex_valid}, 32'd1);
    chk("load_use.fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    chk("load_use.fwd_b", {30'd0, fwd_b_sel}, 32'd1);

    // Double match: EX and MEM both write x5, then an x0 writer
    drain();
    present(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0);
    step("dbl_w1");
    present(1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b0);
    step("dbl_w2");
    present(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0);
    step("dbl_rd");
    chk("double.fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    chk("double.fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    drain();
    present(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
    step("x0_w");
    present(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    step("x0_rd");
    chk("x0.fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    chk("x0.fwd_b", {30'd0, fwd_b_sel}, 32'd0);

    // Hold for three cycles with changing inputs
    present(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0);
    step("pre_hold");
    saved = m;
    hold  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
      flush = (i == 1);
      step("hold");
      chk("hold.pc", ex_pc, saved.pc);
      chk("hold.fwd_a", {30'd0, fwd_a_sel}, {30'd0, saved.fa});
    end
    hold  = 1'b0;
    flush = 1'b0;

    // Flush with a load-use pending: single bubble
    drain();
    present(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    step("fl_lw");
    present(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_lu.stall", {31'd0, load_use_stall}, 32'd1);
    step("fl_bubble");
    chk("flush_lu.valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_lu.reg_write", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0;
    step("fl_next");
    chk("flush_lu.next_valid", {31'd0, ex_valid}, 32'd1);
    chk("flush_lu.next_fwd_a", {30'd0, fwd_a_sel}, 32'd1);

    // Randomized traffic on a small register window to provoke matches
    auto_mem = 1'b0;
    for (int i = 0; i < 400; i++) begin
      present(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom));
      hold          = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
